// File: rtl/fetch_line_builder_if.sv
// Fetch-side and memory-side handshake bundle for the 16-byte line builder.
// slave is the builder's view, master is the fetch stage plus memory.
interface fetch_line_builder_if;
    logic         flush;
    logic         fetch_req;
    logic [31:0]  fetch_addr;
    logic [127:0] fetch_rdata;
    logic         fetch_ack;
    logic [31:0]  mem_addr;
    logic         mem_rd;
    logic         mem_gnt;
    logic [31:0]  mem_rdata;
    logic         mem_rvalid;
    logic         busy;

    modport slave (
        input  flush, fetch_req, fetch_addr, mem_gnt, mem_rdata, mem_rvalid,
        output fetch_rdata, fetch_ack, mem_addr, mem_rd, busy
    );

    modport master (
        output flush, fetch_req, fetch_addr, mem_gnt, mem_rdata, mem_rvalid,
        input  fetch_rdata, fetch_ack, mem_addr, mem_rd, busy
    );
endinterface

// File: rtl/fetch_line_builder.sv
// Builds a 16-byte big-endian fetch line from 4 or 5 word reads, one read in flight,
// with flush-abort and a drain state that swallows the response of an abandoned read.
module fetch_line_builder (
    input  logic                  clk,
    input  logic                  rst_n,
    fetch_line_builder_if.slave   bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    logic [2:0]   state, state_nxt;
    logic [1:0]   off_q;
    logic [2:0]   n_words;
    logic [2:0]   idx;
    logic [159:0] asm_q;
    logic [159:0] asm_nxt;
    logic [127:0] line_q;
    logic [127:0] line_nxt;
    logic [31:0]  addr_q;
    logic         capture;
    logic         word_take;
    logic         last_word;

    assign capture   = (state == IDLE) && bus.fetch_req && !bus.flush;
    assign word_take = (state == WAIT) && bus.mem_rvalid && !bus.flush;
    assign last_word = ((idx + 3'd1) == n_words);
    assign asm_nxt   = {asm_q[127:0], bus.mem_rdata};

    // Bytes off..off+15 of the assembled stream; with off==0 only four words were read.
    always_comb begin
        case (off_q)
            2'd1:    line_nxt = asm_nxt[151:24];
            2'd2:    line_nxt = asm_nxt[143:16];
            2'd3:    line_nxt = asm_nxt[135:8];
            default: line_nxt = asm_nxt[127:0];
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (capture) state_nxt = REQ;
            end
            REQ: begin
                // A grant in the flush cycle leaves a read in flight that must be drained.
                if (bus.flush)        state_nxt = bus.mem_gnt ? DRAIN : IDLE;
                else if (bus.mem_gnt) state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.flush)           state_nxt = bus.mem_rvalid ? IDLE : DRAIN;
                else if (bus.mem_rvalid) state_nxt = last_word ? DONE : REQ;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            DRAIN: begin
                if (bus.mem_rvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            off_q   <= 2'd0;
            n_words <= 3'd0;
            idx     <= 3'd0;
            asm_q   <= '0;
            line_q  <= '0;
            addr_q  <= 32'd0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                addr_q  <= {bus.fetch_addr[31:2], 2'b00};
                off_q   <= bus.fetch_addr[1:0];
                n_words <= (bus.fetch_addr[1:0] == 2'd0) ? 3'd4 : 3'd5;
                idx     <= 3'd0;
                asm_q   <= '0;
            end else if (word_take) begin
                asm_q  <= asm_nxt;
                idx    <= idx + 3'd1;
                addr_q <= addr_q + 32'd4;
                if (last_word) line_q <= line_nxt;
            end
        end
    end

    assign bus.mem_rd      = (state == REQ);
    assign bus.mem_addr    = addr_q;
    assign bus.fetch_ack   = (state == DONE) && !bus.flush;
    assign bus.fetch_rdata = line_q;
    assign bus.busy        = (state != IDLE);

    // Leading bytes fall off the line select; the register width is kept for stream alignment.
    logic unused_hi;
    assign unused_hi = ^{asm_q[159:128], asm_nxt[159:152]};
endmodule

// File: tb/tb_fetch_line_builder.sv
// Directed bench for fetch_line_builder: memory responder, ack scoreboard, address checks.
module tb_fetch_line_builder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_line_builder_if bus();
    fetch_line_builder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [127:0] line;
        int           ack_cyc;
    } exp_t;

    exp_t         exp_q[$];
    logic [31:0]  addr_q[$];
    logic [31:0]  mem [bit [31:0]];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           stall = 0;
    int           rv_delay = 1;
    int           rv_cnt = 0;
    int           rv_issued = 0;
    logic [31:0]  rv_data = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic load_bytes(input logic [31:0] start, input int nw);
        logic [31:0] a;
        for (int i = 0; i < nw; i++) begin
            a = start + 32'(4 * i);
            mem[a] = {a[7:0], a[7:0] + 8'd1, a[7:0] + 8'd2, a[7:0] + 8'd3};
        end
    endtask

    task automatic issue(input logic [31:0] a, input bit push, input logic [127:0] line, input int lat);
        exp_t e;
        @(negedge clk);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        if (push) begin
            e.line    = line;
            e.ack_cyc = (lat < 0) ? -1 : cyc + 1 + lat;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.fetch_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 128'(bus.busy), 128'd0);
    endtask

    // Memory: grants after 'stall' cycles, answers 'rv_delay' cycles after the grant.
    initial begin
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rv_data;
                    rv_issued++;
                end
            end
            bus.mem_gnt = 1'b0;
            if (bus.mem_rd) begin
                if (addr_q.size() == 0) begin
                    chk("unexpected_req", 128'(bus.mem_addr), 128'hFFFF_FFFF_FFFF);
                end else begin
                    chk("req_addr", 128'(bus.mem_addr), 128'(addr_q[0]));
                end
                if (stall > 0) begin
                    stall--;
                end else begin
                    chk("one_outstanding", 128'(rv_cnt), 128'd0);
                    bus.mem_gnt = 1'b1;
                    rv_cnt  = rv_delay;
                    rv_data = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'd0;
                    if (addr_q.size() > 0) void'(addr_q.pop_front());
                end
            end
        end
    end

    // Scoreboard monitor for completed lines.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.fetch_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", bus.fetch_rdata, 128'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("line", bus.fetch_rdata, e.line);
                    if (e.ack_cyc >= 0) chk("ack_cycle", 128'(cyc), 128'(e.ack_cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_before;
        bus.flush      = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rdata", bus.fetch_rdata, 128'd0);
        chk("rst_ack",   128'(bus.fetch_ack), 128'd0);
        chk("rst_mem_rd", 128'(bus.mem_rd), 128'd0);
        chk("rst_busy",  128'(bus.busy), 128'd0);
        chk("rst_addr",  128'(bus.mem_addr), 128'd0);
        rst_n = 1'b1;

        // Flush in IDLE blocks capture
        @(negedge clk);
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h100; bus.flush = 1'b1;
        @(negedge clk);
        bus.fetch_req = 1'b0; bus.flush = 1'b0;
        chk("idle_flush_busy", 128'(bus.busy), 128'd0);
        chk("idle_flush_rd",   128'(bus.mem_rd), 128'd0);

        // Aligned fetch
        mem[32'h100] = 32'h00112233; mem[32'h104] = 32'h44556677;
        mem[32'h108] = 32'h8899AABB; mem[32'h10C] = 32'hCCDDEEFF;
        addr_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
        issue(32'h100, 1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 8);
        wait_idle("aligned_idle");

        // Unaligned fetch
        load_bytes(32'h100, 5);
        addr_q = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
        issue(32'h102, 1'b1, 128'h02030405_06070809_0A0B0C0D_0E0F1011, 10);
        wait_idle("unaligned_idle");

        // Address wrap
        load_bytes(32'hFFFF_FFFC, 1);
        load_bytes(32'h0, 4);
        addr_q = '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC};
        issue(32'hFFFF_FFFE, 1'b1, 128'hFEFF0001_02030405_06070809_0A0B0C0D, 10);
        wait_idle("wrap_idle");

        // Grant stall of 5 cycles on the first word
        addr_q = '{32'h104, 32'h108, 32'h10C, 32'h110};
        stall = 5;
        issue(32'h104, 1'b1, 128'h04050607_08090A0B_0C0D0E0F_10111213, -1);
        wait_idle("stall_idle");

        // Flush in REQ drops the request next cycle
        addr_q = '{32'h300};
        stall = 10;
        issue(32'h300, 1'b0, 128'd0, -1);
        chk("req_rd_before_flush", 128'(bus.mem_rd), 128'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("req_flush_rd",   128'(bus.mem_rd), 128'd0);
        chk("req_flush_busy", 128'(bus.busy), 128'd0);
        stall = 0;
        addr_q.delete();

        // Flush in WAIT, late response drained, then a fetch to 0x200
        mem[32'h200] = 32'hDEADBEEF; mem[32'h204] = 32'h01234567;
        mem[32'h208] = 32'h89ABCDEF; mem[32'h20C] = 32'hCAFEF00D;
        mem[32'h100] = 32'h00112233;
        addr_q = '{32'h100, 32'h200, 32'h204, 32'h208, 32'h20C};
        rv_delay = 3;
        rv_before = rv_issued;
        issue(32'h100, 1'b0, 128'd0, -1);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        rv_delay = 1;
        exp_q.push_back('{line: 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, ack_cyc: -1});
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h200;
        for (int n = 0; n < 30 && !bus.mem_rd; n++) @(negedge clk);
        bus.fetch_req = 1'b0;
        chk("drain_rd_seen", 128'(bus.mem_rd), 128'd1);
        chk("drain_before_req", 128'(rv_issued - rv_before), 128'd1);
        chk("drain_req_addr", 128'(bus.mem_addr), 128'h200);
        wait_idle("drain_idle");

        // Flush during DONE suppresses the ack
        addr_q = '{32'h200, 32'h204, 32'h208, 32'h20C};
        issue(32'h200, 1'b0, 128'd0, -1);
        repeat (7) @(negedge clk);
        @(posedge clk); #1 bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("done_flush_busy", 128'(bus.busy), 128'd0);

        // Reset in WAIT, stray response after release
        addr_q = '{32'h100};
        rv_delay = 3;
        rv_before = rv_issued;
        issue(32'h100, 1'b0, 128'd0, -1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rdata", bus.fetch_rdata, 128'd0);
        chk("async_busy",  128'(bus.busy), 128'd0);
        chk("async_rd",    128'(bus.mem_rd), 128'd0);
        chk("async_addr",  128'(bus.mem_addr), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("stray_seen",  128'(rv_issued - rv_before), 128'd1);
        chk("stray_busy",  128'(bus.busy), 128'd0);
        chk("stray_rdata", bus.fetch_rdata, 128'd0);
        chk("stray_addr",  128'(bus.mem_addr), 128'd0);
        rv_delay = 1;

        repeat (5) @(negedge clk);
        chk("lines_left", 128'(exp_q.size()), 128'd0);
        chk("addrs_left", 128'(addr_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_line_builder.md
FETCH_LINE_BUILDER -- requirements
Module: fetch_line_builder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 flush  input  1  branch redirect; abort the current line fetch.
REQ-005 fetch_req  input  1  line request from the fetch stage.
REQ-006 fetch_addr  input  32  byte address of the first byte of the requested line.
REQ-007 fetch_rdata  output  128  16-byte line, big-endian: the byte at fetch_addr is in [127:120].
REQ-008 fetch_ack  output  1  one-cycle pulse; fetch_rdata is valid in that cycle.
REQ-009 mem_addr  output  32  word-aligned read address to the unified memory.
REQ-010 mem_rd  output  1  read request; held until granted.
REQ-011 mem_gnt  input  1  memory accepted the request in this cycle.
REQ-012 mem_rdata  input  32  read word, big-endian.
REQ-013 mem_rvalid  input  1  mem_rdata is valid.
REQ-014 busy  output  1  high when state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, REQ, WAIT, DONE and DRAIN.
REQ-016 In IDLE, when fetch_req=1 and flush=0, the block SHALL capture base={fetch_addr[31:2],2'b00}, off=fetch_addr[1:0] and N=(off==0)?4:5, clear the word index, and enter REQ.
REQ-017 In REQ, mem_rd=1 and mem_addr=base+4*index SHALL be driven (mod 2^32); both SHALL stay stable until mem_gnt=1, and mem_gnt=1 SHALL move the FSM to WAIT.
REQ-018 At most one memory read SHALL be outstanding at any time.
REQ-019 In WAIT, mem_rvalid=1 SHALL shift mem_rdata into a 160-bit assembly register from the low end and increment index; if index reaches N the FSM SHALL enter DONE, otherwise REQ.
REQ-020 On entry to DONE, fetch_rdata SHALL be registered as assembly bytes off..off+15 counted from the first word's MSB; fetch_ack SHALL be 1 for the single DONE cycle; the next state SHALL be IDLE.
REQ-021 fetch_rdata SHALL hold its value until the next DONE.
REQ-022 With mem_gnt=1 whenever mem_rd=1 and mem_rvalid one cycle after grant, fetch_ack SHALL assert 2N+1 cycles after the capture edge (9 aligned, 11 unaligned).
REQ-023 Deasserting fetch_req after capture SHALL NOT abort the transaction; only flush aborts.
REQ-024 flush=1 in REQ SHALL return the FSM to IDLE with mem_rd=0 in the next cycle; if mem_gnt=1 in the same cycle, the FSM SHALL go to DRAIN instead.
REQ-025 flush=1 in WAIT SHALL enter DRAIN, unless mem_rvalid=1 in the same cycle, in which case the word SHALL be discarded and the FSM SHALL go to IDLE.
REQ-026 DRAIN SHALL wait for mem_rvalid, discard the word, enter IDLE, and issue no new request.
REQ-027 flush=1 in DONE SHALL force fetch_ack=0 and leave fetch_rdata unchanged.
REQ-028 flush=1 in IDLE SHALL block capture in that cycle.
REQ-029 mem_rvalid in IDLE, REQ or DONE SHALL be ignored.
REQ-030 Word-address increments SHALL wrap modulo 2^32.

Reset
REQ-031 When rst_n=0, the FSM SHALL enter IDLE immediately, independent of clk.
REQ-032 When rst_n=0, fetch_rdata, the assembly register, index, mem_addr and N SHALL clear to 0.
REQ-033 When rst_n=0, fetch_ack, mem_rd and busy SHALL be 0.
REQ-034 A response arriving after reset deasserts for a read issued before reset SHALL be ignored per REQ-029.

Verification
REQ-035 Aligned fetch: fetch_addr=0x100, words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, immediate grant, rvalid +1 -> mem_addr 0x100/0x104/0x108/0x10C; fetch_ack on cycle 9; fetch_rdata=0x00112233_44556677_8899AABB_CCDDEEFF.
REQ-036 Unaligned fetch: fetch_addr=0x102, memory byte k holds k for 0x100..0x113 -> five reads 0x100..0x110; fetch_ack on cycle 11; fetch_rdata=0x02030405_06070809_0A0B0C0D_0E0F1011.
REQ-037 Wrap: fetch_addr=0xFFFFFFFE -> mem_addr sequence 0xFFFFFFFC, 0x0, 0x4, 0x8, 0xC; fetch_rdata correct.
REQ-038 Grant stall: mem_gnt held 0 for 5 cycles in REQ -> mem_rd=1 and mem_addr unchanged for all 5 cycles; data correct after grant.
REQ-039 Flush in WAIT, rvalid 3 cycles later, new fetch_req to 0x200 -> no fetch_ack for the first fetch; first mem_rd for 0x200 only after the drained rvalid; correct line for 0x200 returned.
REQ-040 rst_n=0 mid-WAIT, then a stray mem_rvalid after release -> outputs 0 without a clock edge, busy=0, stray word ignored, no fetch_ack.
